// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Holds FSM states, port identifiers, access-size encodings and default memory geometry.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    localparam logic [31:0] DEF_STARTING_ADDR   = 32'h0100_0000;
    localparam logic [31:0] DEF_MEM_DEPTH_BYTES = 32'h0010_0000;

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half lane handling for a little-endian 32-bit memory word:
// load extraction with sign/zero extension, and sub-word store merge.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    function automatic logic [31:0] extend_byte(input logic signed [7:0] b, input logic zext);
        logic signed [31:0] s;
        s = b;
        return zext ? {24'h0, b} : s;
    endfunction

    function automatic logic [31:0] extend_half(input logic signed [15:0] h, input logic zext);
        logic signed [31:0] s;
        s = h;
        return zext ? {16'h0, h} : s;
    endfunction

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane  = word[{byte_off, 3'b000} +: 8];
        half_lane  = word[{byte_off[1], 4'b0000} +: 16];
        load_data  = word;
        store_data = wdata;
        case (size)
            SIZE_BYTE: begin
                load_data  = extend_byte(byte_lane, zero_ext);
                store_data = word;
                store_data[{byte_off, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                load_data  = extend_half(half_lane, zero_ext);
                store_data = word;
                store_data[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-ported word memory with
// round-robin tie breaking, fault checking and read-modify-write sub-word stores.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter logic [31:0] STARTING_ADDR   = DEF_STARTING_ADDR,
    parameter logic [31:0] MEM_DEPTH_BYTES = DEF_MEM_DEPTH_BYTES
)(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_read_write
);

    localparam logic [32:0] LAST_WORD_ADDR =
        {1'b0, STARTING_ADDR} + {1'b0, MEM_DEPTH_BYTES} - 33'd4;

    function automatic logic access_fault(input logic [31:0] addr, input logic [1:0] size);
        logic misaligned;
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = addr[0];
            SIZE_WORD: misaligned = (addr[1:0] != 2'b00);
            default:   misaligned = 1'b1;
        endcase
        return misaligned || (addr < STARTING_ADDR) || ({1'b0, addr} > LAST_WORD_ADDR);
    endfunction

    state_t      state, state_nxt;
    port_t       last_grant, req_port, lat_port, resp_port;
    logic        any_req, req_we, req_fault;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] lat_addr, lat_wdata, cap_word;
    logic [1:0]  lat_size;
    logic        lat_uns;
    logic        resp_vld, resp_err;
    logic [31:0] resp_rdata, align_word, load_data, store_data;

    // Grant decode: data wins a tie unless it was granted last
    always_comb begin
        any_req   = if_req | d_req;
        req_port  = (d_req && (!if_req || last_grant == PORT_FETCH)) ? PORT_DATA : PORT_FETCH;
        req_addr  = (req_port == PORT_DATA) ? d_addr : if_addr;
        req_size  = (req_port == PORT_DATA) ? d_size : SIZE_WORD;
        req_we    = (req_port == PORT_DATA) && d_we;
        req_fault = access_fault(req_addr, req_size);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= PORT_FETCH;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req)
                last_grant <= req_port;
        end
    end

    always_comb begin
        state_nxt      = state;
        resp_vld       = 1'b0;
        resp_port      = lat_port;
        resp_err       = 1'b0;
        resp_rdata     = 32'h0;
        mem_address    = STARTING_ADDR;
        mem_read_write = MEM_READ;
        mem_data_in    = 32'h0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (req_fault) begin
                        state_nxt = RESP;
                        resp_vld  = 1'b1;
                        resp_port = req_port;
                        resp_err  = 1'b1;
                    end else if (!req_we)
                        state_nxt = ACCESS;
                    else if (req_size == SIZE_WORD)
                        state_nxt = WR;
                    else
                        state_nxt = RMW_RD;
                end
            end
            ACCESS: begin
                mem_address = {lat_addr[31:2], 2'b00};
                state_nxt   = RESP;
                resp_vld    = 1'b1;
                resp_rdata  = load_data;
            end
            RMW_RD: begin
                mem_address = {lat_addr[31:2], 2'b00};
                state_nxt   = WR;
            end
            WR: begin
                mem_address    = {lat_addr[31:2], 2'b00};
                mem_read_write = MEM_WRITE;
                mem_data_in    = store_data;
                state_nxt      = RESP;
                resp_vld       = 1'b1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture at grant; requester inputs are ignored afterwards
    always_ff @(posedge clock) begin
        if (state == IDLE && any_req) begin
            lat_port  <= req_port;
            lat_addr  <= req_addr;
            lat_size  <= req_size;
            lat_uns   <= d_unsigned;
            lat_wdata <= d_wdata;
        end
        if (state == RMW_RD)
            cap_word <= mem_data_out;
    end

    assign align_word = (state == WR) ? cap_word : mem_data_out;

    mem_lane_align u_lane_align (
        .word       (align_word),
        .byte_off   (lat_addr[1:0]),
        .size       (lat_size),
        .zero_ext   (lat_uns),
        .wdata      (lat_wdata),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // Response stage: strobes last one cycle, read data holds until the next response
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            if_done  <= 1'b0;
            if_err   <= 1'b0;
            if_rdata <= 32'h0;
            d_done   <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= 32'h0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            if (resp_vld) begin
                if (resp_port == PORT_DATA) begin
                    d_done  <= 1'b1;
                    d_err   <= resp_err;
                    d_rdata <= resp_rdata;
                end else begin
                    if_done  <= 1'b1;
                    if_err   <= resp_err;
                    if_rdata <= resp_rdata;
                end
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARTING_ADDR, default 'h01000000, the byte address of memory location 0.
REQ-002 SHALL have parameter MEM_DEPTH_BYTES, default 'h0100000, the memory size in bytes.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; ports: clock in 1, rising-edge clock; reset_n in 1, asynchronous active-low reset.
REQ-004 SHALL have instruction-fetch ports: if_req in 1, fetch request; if_addr in 32, fetch byte address; if_done out 1, one-cycle response strobe; if_rdata out 32, fetched word; if_err out 1, fetch fault qualified by if_done.
REQ-005 SHALL have data ports: d_req in 1; d_we in 1 (1 store); d_size in 2 (0 byte, 1 half, 2 word, 3 illegal); d_unsigned in 1 (load zero-extend); d_addr in 32; d_wdata in 32; d_done out 1; d_rdata out 32; d_err out 1.
REQ-006 SHALL have memory-side ports: mem_address out 32; mem_data_in out 32 (write data); mem_data_out in 32 (combinational read data, little-endian); mem_read_write out 1 (0 READ, 1 WRITE; memory writes the full word on the rising edge while WRITE).

Function
REQ-007 SHALL use FSM states IDLE, ACCESS (read), RMW_RD, WR, RESP.
REQ-008 SHALL sample requests in IDLE at the rising edge; with one request pending, grant it; with both pending, grant the port not granted last; after reset, data wins the first tie.
REQ-009 SHALL latch the granted port's address, size, we, unsigned and wdata at grant; later changes to requester inputs SHALL be ignored until RESP.
REQ-010 SHALL perform a fault check at grant: word with addr[1:0]!=0, half with addr[0]=1, d_size=3, fetch with addr[1:0]!=0, or addr outside [STARTING_ADDR, STARTING_ADDR+MEM_DEPTH_BYTES-4]; on fault, go IDLE->RESP with err=1, no memory access, and rdata=0.
REQ-011 SHALL take these paths: load/fetch IDLE->ACCESS->RESP; word store IDLE->WR->RESP; byte/half store IDLE->RMW_RD->WR->RESP.
REQ-012 SHALL drive mem_address = {addr[31:2],2'b00} of the latched request in ACCESS, RMW_RD and WR, and STARTING_ADDR otherwise.
REQ-013 SHALL drive mem_read_write=1 only in WR, decoded from the state register, and mem_data_in=0 outside WR.
REQ-014 SHALL capture mem_data_out at the end of ACCESS/RMW_RD.
REQ-015 SHALL produce load data by selecting the byte/half lane at addr[1:0] and sign-extending, or zero-extending when d_unsigned=1.
REQ-016 SHALL form sub-word store data in WR by replacing only the addressed byte/half lane of the word captured in RMW_RD with d_wdata[7:0]/[15:0]; other bytes SHALL be unchanged.
REQ-017 SHALL assert exactly one of if_done/d_done for exactly one cycle in RESP, with rdata/err valid that cycle; a store returns d_rdata=0.
REQ-018 SHALL hold rdata outputs until the next RESP.
REQ-019 SHALL go RESP->IDLE unconditionally; a request still high in IDLE starts a new transaction (back-to-back allowed, minimum 3 cycles per load).
REQ-020 SHALL never assert a done output for a port whose request was not granted; the losing requester keeps req high and is served next.

Reset
REQ-021 SHALL on reset_n low immediately (asynchronously) force state IDLE, if_done=d_done=0, if_err=d_err=0, if_rdata=d_rdata=0, mem_read_write=0, mem_data_in=0, mem_address=STARTING_ADDR, last-grant=fetch.
REQ-022 SHALL, on reset asserted during WR, return mem_read_write to 0 before the next clock edge so that no partial write occurs, and discard the aborted transaction.

Structure
REQ-023 SHALL place the FSM state enum, the READ/WRITE constants, the d_size encodings and the default STARTING_ADDR/MEM_DEPTH_BYTES in shared package mem_pkg.
REQ-024 SHALL place the load-extract/extend and store-merge logic in one combinational sub-module, mem_lane_align.

Verification
REQ-025 SHALL cover: memory word at 'h01000010 = 'h8899AABB; d lb at 'h01000011 -> d_done 2 cycles after grant edge, d_rdata='hFFFFFFAA; lbu -> 'h000000AA; lhu at 'h01000012 -> 'h00008899.
REQ-026 SHALL cover: sb d_wdata='h55 at 'h01000012 on word 'h8899AABB -> RMW_RD, WR, RESP; memory word='h8855AABB; mem_read_write high exactly one cycle.
REQ-027 SHALL cover: if_req and d_req raised the same cycle after reset -> data served first, fetch if_done 3 cycles later; repeated ties alternate grants.
REQ-028 SHALL cover: lw at 'h01000002 and fetch at 'h00FFFFFC -> err=1, done one cycle after grant, mem_read_write never 1, rdata=0.
REQ-029 SHALL cover: reset_n dropped mid-WR of sw 'hDEADBEEF -> mem_read_write 0 before the next edge, target word unchanged, all outputs at reset values.
